// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: test-pattern source feeding the HDMI transmitter colour inputs.
// Computes each pixel one cycle ahead of the transmitter counters and registers it
// so the colour is aligned with the position being encoded. A debounced push-button
// cycles through four patterns; the change is committed at the start of vertical
// blanking. Optional feature macro: PATTERN_ANIMATION_EN (scrolls the colour bars
// two pixels per frame).
module hdmi_pattern_gen #(
  parameter int H_ACTIVE        = 720,
  parameter int V_ACTIVE        = 480,
  parameter int H_WRAP          = 858,
  parameter int V_WRAP          = 525,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       pixelClock,
  input  logic       resetn,
  input  logic [9:0] hPosCounter,
  input  logic [9:0] vPosCounter,
  input  logic       patternNext,
  output logic [7:0] redByte,
  output logic [7:0] greenByte,
  output logic [7:0] blueByte,
  output logic [1:0] patternSel,
  output logic       vblankStart
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [9:0]       hn_s, vn_s, scroll_s;
  logic             next_active_s, commit_s, rise_s;
  logic [10:0]      hb_sum_s, hb_s;
  logic [2:0]       bar_s;
  logic [23:0]      rgb_d, rgb_q;
  logic             sync1_q, sync2_q, deb_d, deb_q, pend_d, pend_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [1:0]       sel_d, sel_q;

  assign commit_s = (hPosCounter == 10'd0) && (vPosCounter == 10'(V_ACTIVE));

`ifdef PATTERN_ANIMATION_EN
  logic [9:0] scroll_d, scroll_q, scroll_inc_s;

  // Advance the bar scroll offset by two pixels per commit, wrapping at the line width.
  always_comb begin
    scroll_inc_s = scroll_q + 10'd2;
    if (!commit_s) begin
      scroll_d = scroll_q;
    end else if (scroll_inc_s >= 10'(H_ACTIVE)) begin
      scroll_d = scroll_inc_s - 10'(H_ACTIVE);
    end else begin
      scroll_d = scroll_inc_s;
    end
  end

  // Scroll offset register.
  always_ff @(posedge pixelClock or negedge resetn) begin
    if (!resetn) scroll_q <= 10'd0;
    else         scroll_q <= scroll_d;
  end

  assign scroll_s = scroll_q;
`else
  assign scroll_s = 10'd0;
`endif

  // Position of the pixel that will be on screen next cycle.
  always_comb begin
    if (hPosCounter == 10'(H_WRAP)) begin
      hn_s = 10'd0;
      if (vPosCounter == 10'(V_WRAP)) vn_s = 10'd0;
      else                            vn_s = vPosCounter + 10'd1;
    end else begin
      hn_s = hPosCounter + 10'd1;
      vn_s = vPosCounter;
    end
  end

  assign next_active_s = (hn_s < 10'(H_ACTIVE)) && (vn_s < 10'(V_ACTIVE));

  // Scrolled horizontal position and colour-bar index by comparison against bar edges.
  always_comb begin
    hb_sum_s = {1'b0, hn_s} + {1'b0, scroll_s};
    if (hb_sum_s >= 11'(H_ACTIVE)) hb_s = hb_sum_s - 11'(H_ACTIVE);
    else                           hb_s = hb_sum_s;
    if      (hb_s < 11'(1 * BAR_W)) bar_s = 3'd0;
    else if (hb_s < 11'(2 * BAR_W)) bar_s = 3'd1;
    else if (hb_s < 11'(3 * BAR_W)) bar_s = 3'd2;
    else if (hb_s < 11'(4 * BAR_W)) bar_s = 3'd3;
    else if (hb_s < 11'(5 * BAR_W)) bar_s = 3'd4;
    else if (hb_s < 11'(6 * BAR_W)) bar_s = 3'd5;
    else if (hb_s < 11'(7 * BAR_W)) bar_s = 3'd6;
    else                            bar_s = 3'd7;
  end

  // Colour of the next pixel from the committed pattern; black outside the active area.
  always_comb begin
    rgb_d = 24'h000000;
    if (next_active_s) begin
      case (sel_q)
        2'd0: begin
          case (bar_s)
            3'd0:    rgb_d = 24'hFFFFFF;
            3'd1:    rgb_d = 24'hFFFF00;
            3'd2:    rgb_d = 24'h00FFFF;
            3'd3:    rgb_d = 24'h00FF00;
            3'd4:    rgb_d = 24'hFF00FF;
            3'd5:    rgb_d = 24'hFF0000;
            3'd6:    rgb_d = 24'h0000FF;
            default: rgb_d = 24'h000000;
          endcase
        end
        2'd1:    rgb_d = {hn_s[9:2], vn_s[8:1], 8'h80};
        2'd2:    rgb_d = (hn_s[4] ^ vn_s[4]) ? 24'hFFFFFF : 24'h000000;
        2'd3:    rgb_d = 24'h808080;
        default: rgb_d = 24'h000000;
      endcase
    end else begin
      rgb_d = 24'h000000;
    end
  end

  // Debounce: count cycles the synchronised level disagrees with the accepted level.
  always_comb begin
    deb_d  = deb_q;
    cnt_d  = '0;
    rise_s = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d  = sync2_q;
        cnt_d  = '0;
        rise_s = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Pending advance and committed pattern; an edge coinciding with a commit waits a frame.
  always_comb begin
    if (commit_s) begin
      pend_d = rise_s;
      if (pend_q) sel_d = sel_q + 2'd1;
      else        sel_d = sel_q;
    end else begin
      pend_d = pend_q | rise_s;
      sel_d  = sel_q;
    end
  end

  // State and output registers.
  always_ff @(posedge pixelClock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      sel_q   <= 2'd0;
      rgb_q   <= 24'h000000;
    end else begin
      sync1_q <= patternNext;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      rgb_q   <= rgb_d;
    end
  end

  assign redByte     = rgb_q[23:16];
  assign greenByte   = rgb_q[15:8];
  assign blueByte    = rgb_q[7:0];
  assign patternSel  = sel_q;
  assign vblankStart = commit_s & resetn;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Self-checking bench for hdmi_pattern_gen: a frame-level reference model is checked
// against the DUT every cycle, plus literal pixel/pattern expectations.
module tb_hdmi_pattern_gen;
  localparam int D = 200;

  logic       pixelClock = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] hPos = 10'd100, vPos = 10'd100;
  logic       btn = 1'b0;
  logic [7:0] redByte, greenByte, blueByte;
  logic [1:0] patternSel;
  logic       vblankStart;

  int errors = 0;
  int checks = 0;

  hdmi_pattern_gen #(.DEBOUNCE_CYCLES(D)) dut (
    .pixelClock(pixelClock), .resetn(resetn),
    .hPosCounter(hPos), .vPosCounter(vPos), .patternNext(btn),
    .redByte(redByte), .greenByte(greenByte), .blueByte(blueByte),
    .patternSel(patternSel), .vblankStart(vblankStart));

  always #5 pixelClock = ~pixelClock;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (h=%0d v=%0d t=%0t)", name, act, exp, hPos, vPos, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [23:0] bar_colour(int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] pix(int x, int y, int pat, int scr);
    if (x >= 720 || y >= 480) return 24'h000000;
    case (pat)
      0: return bar_colour(((x + scr) % 720) / 90);
      1: return {8'(x / 4), 8'(y / 2), 8'h80};
      2: return (((x / 16) % 2) != ((y / 16) % 2)) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h808080;
    endcase
  endfunction

  function automatic int la_x(int h);
    return (h + 1) % 859;
  endfunction

  function automatic int la_y(int h, int v);
    return (h == 858) ? (v + 1) % 526 : v;
  endfunction

  logic [23:0] m_rgb;
  int          m_sel, m_scroll, m_run;
  logic        m_pend, m_s1, m_s2, m_deb;
  logic        m_rise;

  // Accepted rising edge: the delayed button has been high while accepted level low for D cycles.
  assign m_rise = m_s2 && !m_deb && (m_run + 1 == D);

  always @(posedge pixelClock or negedge resetn) begin
    if (!resetn) begin
      m_rgb <= 24'h0; m_sel <= 0; m_scroll <= 0; m_run <= 0;
      m_pend <= 1'b0; m_s1 <= 1'b0; m_s2 <= 1'b0; m_deb <= 1'b0;
    end else begin
      m_rgb <= pix(la_x(hPos), la_y(hPos, vPos), m_sel, m_scroll);
      m_s1 <= btn;
      m_s2 <= m_s1;
      if (m_s2 != m_deb) begin
        if (m_run + 1 == D) begin
          m_deb <= m_s2;
          m_run <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
      if (hPos == 10'd0 && vPos == 10'd480) begin
        if (m_pend) m_sel <= (m_sel + 1) % 4;
        m_pend <= m_rise;
`ifdef PATTERN_ANIMATION_EN
        m_scroll <= (m_scroll + 2) % 720;
`endif
      end else begin
        m_pend <= m_pend || m_rise;
      end
    end
  end

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge pixelClock) begin
    check("rgb", 32'({redByte, greenByte, blueByte}), 32'(m_rgb));
    check("sel", 32'(patternSel), 32'(m_sel));
    check("vblank", 32'(vblankStart), 32'(resetn && hPos == 10'd0 && vPos == 10'd480));
  end

  // ---------------- stimulus ----------------
  task automatic step(int h, int v);
    hPos = 10'(h);
    vPos = 10'(v);
    @(negedge pixelClock);
    #1;
  endtask

  task automatic step_rand();
    step($urandom_range(1, 858), $urandom_range(0, 525));
  endtask

  task automatic pin(int x, int y, logic [23:0] exp, string name);
    if (x > 0) step(x - 1, y);
    else       step(858, (y == 0) ? 525 : y - 1);
    check(name, 32'({redByte, greenByte, blueByte}), 32'(exp));
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (D + 10) step_rand();
    btn = 1'b0;
    repeat (D + 10) step_rand();
  endtask

  task automatic run_seq(int h0, int v0, int n, output int pulses);
    int h, v;
    h = h0; v = v0; pulses = 0;
    repeat (n) begin
      step(h, v);
      if (vblankStart) pulses++;
      v = la_y(h, v);
      h = la_x(h);
    end
  endtask

  initial begin
    int p, hold, r;
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};

    // Reset defaults
    repeat (3) step(100, 100);
    check("reset_rgb", 32'({redByte, greenByte, blueByte}), 32'h0);
    check("reset_sel", 32'(patternSel), 32'd0);
    resetn = 1'b1;

    // Colour bars and blanking, including the (858,525) lookahead wrap
    pin(0, 0, 24'hFFFFFF, "pix_0_0");
    pin(90, 0, 24'hFFFF00, "pix_90_0");
    pin(719, 0, 24'h000000, "pix_719_0");
    pin(720, 0, 24'h000000, "pix_720_0");
    pin(0, 479, 24'hFFFFFF, "pix_0_479");
    pin(0, 480, 24'h000000, "pix_0_480");

    // Short glitch is ignored
    btn = 1'b1;
    repeat (100) step_rand();
    btn = 1'b0;
    repeat (D + 50) step_rand();
    step(0, 480);
    check("glitch_sel", 32'(patternSel), 32'd0);

    // One valid press, committed only at (0,480)
    press();
    check("pre_commit_sel", 32'(patternSel), 32'd0);
    step(0, 480);
    check("commit_vblank", 32'(vblankStart), 32'd1);
    check("commit_sel", 32'(patternSel), 32'd1);
    pin(400, 200, 24'h646480, "gradient_400_200");

    // Two presses in one frame give one advance
    press();
    press();
    step(0, 480);
    check("two_press_sel", 32'(patternSel), 32'd2);
    pin(16, 0, 24'hFFFFFF, "checker_16_0");
    pin(16, 16, 24'h000000, "checker_16_16");

    // Edge accepted in the commit cycle stays pending for the next frame
    btn = 1'b1;
    repeat (D + 1) step_rand();
    step(0, 480);
    check("coincident_sel", 32'(patternSel), 32'd2);
    btn = 1'b0;
    repeat (D + 10) step_rand();
    step(0, 480);
    check("deferred_sel", 32'(patternSel), 32'd3);

    // Advances wrap 3 -> 0 -> 1 -> 2 -> 3 -> 0
    for (int i = 0; i < 5; i++) begin
      press();
      step(0, 480);
      check("wrap_sel", 32'(patternSel), 32'(exp_seq[i]));
    end

    // Mid-frame reset with a non-zero pattern
    press();
    step(0, 480);
    step(100, 100);
    #2 resetn = 1'b0;
    #1;
    check("midreset_rgb", 32'({redByte, greenByte, blueByte}), 32'h0);
    check("midreset_sel", 32'(patternSel), 32'd0);
    step(100, 100);
    step(100, 100);
    resetn = 1'b1;

    // Bar scrolling over 45 and 360 commits
    repeat (45) begin step(0, 480); step(5, 5); end
`ifdef PATTERN_ANIMATION_EN
    pin(0, 0, 24'hFFFF00, "scroll45_0_0");
`else
    pin(0, 0, 24'hFFFFFF, "scroll45_0_0");
`endif
    repeat (315) begin step(0, 480); step(5, 5); end
    pin(0, 0, 24'hFFFFFF, "scroll360_0_0");
    pin(90, 0, 24'hFFFF00, "scroll360_90_0");

    // Sequential scans: one vblank pulse near line 480, none across the frame wrap
    run_seq(840, 478, 1800, p);
    check("vblank_pulses", 32'(p), 32'd1);
    run_seq(850, 524, 30, p);
    check("wrap_pulses", 32'(p), 32'd0);

    // Randomised phase
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        btn = ~btn;
        hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : int'($urandom_range(D, D + 40));
      end
      hold--;
      r = $urandom_range(0, 199);
      if (r < 6) begin
        step(0, 480);
      end else if (r == 6) begin
        #2 resetn = 1'b0;
        step_rand();
        resetn = 1'b1;
      end else begin
        step($urandom_range(0, 858), $urandom_range(0, 525));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
